// File: rtl/pcie_app_rst_seq_if.sv
// Signal bundle between the PCIe application reset sequencer and its surroundings.
// The sequencer uses the slave view; the stimulus side (HIP/engines model) uses the master view.
interface pcie_app_rst_seq_if #(
    parameter int unsigned NUM_ENG = 2
);
    logic               app_rstn;
    logic [4:0]         ltssm;
    logic               sw_rst_req;
    logic [NUM_ENG-1:0] eng_idle;
    logic               clr_status;
    logic               quiesce_req;
    logic [NUM_ENG-1:0] eng_rstn;
    logic               link_up;
    logic               drain_timeout;
    logic [2:0]         seq_state;

    modport master (
        output app_rstn, ltssm, sw_rst_req, eng_idle, clr_status,
        input  quiesce_req, eng_rstn, link_up, drain_timeout, seq_state
    );

    modport slave (
        input  app_rstn, ltssm, sw_rst_req, eng_idle, clr_status,
        output quiesce_req, eng_rstn, link_up, drain_timeout, seq_state
    );
endinterface

// File: rtl/pcie_app_rst_seq.sv
// Application DMA engine reset sequencer: quiesces engines on link loss or SW request, holds
// them in reset, and releases them in staggered order once the link has been stable in L0.
module pcie_app_rst_seq #(
    parameter int unsigned NUM_ENG     = 2,
    parameter int unsigned LINK_STABLE = 64,
    parameter int unsigned STAGE_GAP   = 8,
    parameter int unsigned DRAIN_TO    = 1024,
    parameter int unsigned HOLD_CYC    = 16,
    parameter logic [4:0]  L0_CODE     = 5'h0F
) (
    input  logic                 pld_clk,
    input  logic                 npor,
    pcie_app_rst_seq_if.slave    bus
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned LTW   = 5;

    localparam logic [LTW-1:0]   LTSSM_QUIET  = 5'h00;
    localparam logic [LTW-1:0]   LTSSM_HOTRST = 5'h10;
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LINK_STABLE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_TO - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_WAIT_LINK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_DRAIN     = 3'd4,
        S_HOLD      = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LTW-1:0]     ltssm_r;
    logic [NUM_ENG-1:0] eng_rstn;
    logic               quiesce_req;
    logic               link_up;
    logic               drain_timeout;

    logic               link_ok_c;
    logic               all_idle_c;
    logic               drain_trig_c;
    logic               timeout_c;
    logic               go_hold_c;

    // LTSSM state is sampled once before any decision is made on it.
    always_ff @(posedge pld_clk or negedge npor) begin
        if (!npor) begin
            ltssm_r <= '0;
        end else begin
            ltssm_r <= bus.ltssm;
        end
    end

    assign link_ok_c    = bus.app_rstn && (ltssm_r == L0_CODE);
    assign all_idle_c   = &bus.eng_idle;
    assign drain_trig_c = (ltssm_r == LTSSM_QUIET) || (ltssm_r == LTSSM_HOTRST) || bus.sw_rst_req;
    // Idle beats timeout on the same cycle; app_rstn loss abandons the drain without flagging it.
    assign timeout_c    = (state == S_DRAIN) && bus.app_rstn && !all_idle_c && (cnt == DRAIN_LAST);

    // Every path into HOLD, including recovery from an illegal state code.
    always_comb begin
        go_hold_c = 1'b0;
        case (state)
            S_WAIT_LINK: go_hold_c = 1'b0;
            S_RELEASE:   go_hold_c = !link_ok_c;
            S_RUN:       go_hold_c = !bus.app_rstn;
            S_DRAIN:     go_hold_c = !bus.app_rstn || all_idle_c || (cnt == DRAIN_LAST);
            S_HOLD:      go_hold_c = 1'b0;
            default:     go_hold_c = 1'b1;
        endcase
    end

    // Sequencer state, shared counter and registered outputs.
    always_ff @(posedge pld_clk or negedge npor) begin
        if (!npor) begin
            state         <= S_WAIT_LINK;
            cnt           <= '0;
            eng_rstn      <= '0;
            quiesce_req   <= 1'b0;
            link_up       <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            if (bus.clr_status) begin
                drain_timeout <= 1'b0;
            end
            if (timeout_c) begin
                drain_timeout <= 1'b1;
            end

            if (go_hold_c) begin
                state       <= S_HOLD;
                cnt         <= '0;
                eng_rstn    <= '0;
                quiesce_req <= 1'b0;
                link_up     <= 1'b0;
            end else begin
                case (state)
                    S_WAIT_LINK: begin
                        if (!link_ok_c) begin
                            cnt <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state       <= S_RELEASE;
                            cnt         <= '0;
                            eng_rstn[0] <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    // Engine 0 leaves reset on entry; engine i follows i*STAGE_GAP edges later.
                    S_RELEASE: begin
                        if (eng_rstn[NUM_ENG-1]) begin
                            state   <= S_RUN;
                            cnt     <= '0;
                            link_up <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            for (int i = 1; i < NUM_ENG; i++) begin
                                if (cnt == CNT_W'(i * STAGE_GAP - 1)) begin
                                    eng_rstn[i] <= 1'b1;
                                end
                            end
                        end
                    end

                    S_RUN: begin
                        if (drain_trig_c) begin
                            state       <= S_DRAIN;
                            cnt         <= '0;
                            quiesce_req <= 1'b1;
                            link_up     <= 1'b0;
                        end
                    end

                    S_DRAIN: begin
                        cnt <= cnt + CNT_W'(1);
                    end

                    S_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state <= S_WAIT_LINK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    default: begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.seq_state     = state;
    assign bus.eng_rstn      = eng_rstn;
    assign bus.quiesce_req   = quiesce_req;
    assign bus.link_up       = link_up;
    assign bus.drain_timeout = drain_timeout;

endmodule

// File: tb/tb_pcie_app_rst_seq.sv
// Directed bench for pcie_app_rst_seq: power-up release, link glitch, SW drain, drain timeout,
// app_rstn aborts and asynchronous npor, each checked against hand-computed values.
module tb_pcie_app_rst_seq;

    logic clk;
    logic npor;
    int   n_tests;
    int   n_fail;

    pcie_app_rst_seq_if #(.NUM_ENG(2)) bus ();

    pcie_app_rst_seq #(
        .NUM_ENG    (2),
        .LINK_STABLE(64),
        .STAGE_GAP  (8),
        .DRAIN_TO   (1024),
        .HOLD_CYC   (16),
        .L0_CODE    (5'h0F)
    ) dut (
        .pld_clk(clk),
        .npor   (npor),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
        int n;
        n = 0;
        while (bus.seq_state !== exp && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.seq_state), 32'(exp));
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        npor           = 1'b0;
        bus.app_rstn   = 1'b1;
        bus.ltssm      = 5'h0F;
        bus.sw_rst_req = 1'b0;
        bus.eng_idle   = 2'b00;
        bus.clr_status = 1'b0;

        // Reset values.
        #12;
        chk("rst_state",   32'(bus.seq_state), 32'd1);
        chk("rst_eng",     32'(bus.eng_rstn), 32'd0);
        chk("rst_quiesce", 32'(bus.quiesce_req), 32'd0);
        chk("rst_link",    32'(bus.link_up), 32'd0);
        chk("rst_tmo",     32'(bus.drain_timeout), 32'd0);
        @(posedge clk);
        #1;
        npor = 1'b1;

        // Power-up: RELEASE on the 65th edge, staggered engine release, then RUN.
        repeat (64) tick();
        chk("pu_wait64_state", 32'(bus.seq_state), 32'd1);
        chk("pu_wait64_eng",   32'(bus.eng_rstn), 32'd0);
        tick();
        chk("pu_rel_state", 32'(bus.seq_state), 32'd2);
        chk("pu_rel_eng0",  32'(bus.eng_rstn), 32'b01);
        chk("pu_rel_link",  32'(bus.link_up), 32'd0);
        repeat (7) tick();
        chk("pu_gap7_eng", 32'(bus.eng_rstn), 32'b01);
        tick();
        chk("pu_gap8_eng",   32'(bus.eng_rstn), 32'b11);
        chk("pu_gap8_state", 32'(bus.seq_state), 32'd2);
        tick();
        chk("pu_run_state", 32'(bus.seq_state), 32'd3);
        chk("pu_run_link",  32'(bus.link_up), 32'd1);

        // SW drain: engines go idle after 5 cycles, quiesce high for 6 cycles.
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        chk("sw_drain_state", 32'(bus.seq_state), 32'd4);
        chk("sw_drain_q",     32'(bus.quiesce_req), 32'd1);
        chk("sw_drain_link",  32'(bus.link_up), 32'd0);
        chk("sw_drain_eng",   32'(bus.eng_rstn), 32'b11);
        repeat (5) tick();
        chk("sw_drain5_state", 32'(bus.seq_state), 32'd4);
        chk("sw_drain5_q",     32'(bus.quiesce_req), 32'd1);
        bus.eng_idle = 2'b11;
        tick();
        bus.eng_idle = 2'b00;
        chk("sw_hold_state", 32'(bus.seq_state), 32'd5);
        chk("sw_hold_q",     32'(bus.quiesce_req), 32'd0);
        chk("sw_hold_eng",   32'(bus.eng_rstn), 32'd0);
        chk("sw_hold_tmo",   32'(bus.drain_timeout), 32'd0);

        // HOLD lasts 16 cycles and ignores a SW request.
        repeat (3) tick();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        repeat (11) tick();
        chk("hold15_state", 32'(bus.seq_state), 32'd5);
        chk("hold15_eng",   32'(bus.eng_rstn), 32'd0);
        tick();
        chk("hold_exit_state", 32'(bus.seq_state), 32'd1);

        // LTSSM glitch at cycle 40 of WAIT_LINK restarts the stability count.
        repeat (40) tick();
        bus.ltssm = 5'h0E;
        tick();
        bus.ltssm = 5'h0F;
        repeat (64) tick();
        chk("glitch_wait_state", 32'(bus.seq_state), 32'd1);
        tick();
        chk("glitch_rel_state", 32'(bus.seq_state), 32'd2);
        repeat (9) tick();
        chk("glitch_run_state", 32'(bus.seq_state), 32'd3);
        chk("glitch_run_link",  32'(bus.link_up), 32'd1);

        // Link drops to detect.quiet with one engine stuck busy -> drain timeout.
        bus.eng_idle = 2'b01;
        bus.ltssm    = 5'h00;
        tick();
        chk("tmo_pipe_state", 32'(bus.seq_state), 32'd3);
        tick();
        chk("tmo_drain_state", 32'(bus.seq_state), 32'd4);
        repeat (1023) tick();
        chk("tmo_1023_state", 32'(bus.seq_state), 32'd4);
        chk("tmo_1023_flag",  32'(bus.drain_timeout), 32'd0);
        tick();
        chk("tmo_hold_state", 32'(bus.seq_state), 32'd5);
        chk("tmo_hold_flag",  32'(bus.drain_timeout), 32'd1);
        chk("tmo_hold_q",     32'(bus.quiesce_req), 32'd0);
        chk("tmo_hold_eng",   32'(bus.eng_rstn), 32'd0);
        bus.clr_status = 1'b1;
        bus.ltssm      = 5'h0F;
        tick();
        bus.clr_status = 1'b0;
        chk("tmo_clr_flag", 32'(bus.drain_timeout), 32'd0);
        wait_state("tmo_back_run", 3'd3, 200);

        // Idle arriving on the timeout cycle wins: no flag.
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        chk("tie_drain_state", 32'(bus.seq_state), 32'd4);
        repeat (1023) tick();
        chk("tie_1023_state", 32'(bus.seq_state), 32'd4);
        bus.eng_idle = 2'b11;
        tick();
        bus.eng_idle = 2'b00;
        chk("tie_hold_state", 32'(bus.seq_state), 32'd5);
        chk("tie_hold_flag",  32'(bus.drain_timeout), 32'd0);
        wait_state("tie_back_run", 3'd3, 200);

        // app_rstn loss during DRAIN -> HOLD next edge, no timeout flag.
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        chk("ar_drain_state", 32'(bus.seq_state), 32'd4);
        repeat (2) tick();
        bus.app_rstn = 1'b0;
        tick();
        chk("ar_drain_hold_state", 32'(bus.seq_state), 32'd5);
        chk("ar_drain_hold_eng",   32'(bus.eng_rstn), 32'd0);
        chk("ar_drain_hold_q",     32'(bus.quiesce_req), 32'd0);
        chk("ar_drain_hold_tmo",   32'(bus.drain_timeout), 32'd0);
        bus.app_rstn = 1'b1;

        // app_rstn loss during RELEASE aborts it.
        wait_state("ar_rel_enter", 3'd2, 200);
        repeat (3) tick();
        chk("ar_rel_eng_partial", 32'(bus.eng_rstn), 32'b01);
        bus.app_rstn = 1'b0;
        tick();
        chk("ar_rel_hold_state", 32'(bus.seq_state), 32'd5);
        chk("ar_rel_hold_eng",   32'(bus.eng_rstn), 32'd0);
        chk("ar_rel_hold_link",  32'(bus.link_up), 32'd0);
        bus.app_rstn = 1'b1;
        wait_state("ar_rel_back_run", 3'd3, 200);

        // app_rstn loss in RUN beats a simultaneous SW request: straight to HOLD.
        bus.app_rstn   = 1'b0;
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        chk("prio_state", 32'(bus.seq_state), 32'd5);
        chk("prio_q",     32'(bus.quiesce_req), 32'd0);
        chk("prio_link",  32'(bus.link_up), 32'd0);
        bus.app_rstn = 1'b1;
        wait_state("prio_back_run", 3'd3, 200);
        chk("prio_run_eng", 32'(bus.eng_rstn), 32'b11);

        // npor asserted in RUN: outputs return to reset values without a clock edge.
        @(posedge clk);
        #3;
        npor = 1'b0;
        #1;
        chk("npor_state",   32'(bus.seq_state), 32'd1);
        chk("npor_eng",     32'(bus.eng_rstn), 32'd0);
        chk("npor_link",    32'(bus.link_up), 32'd0);
        chk("npor_q",       32'(bus.quiesce_req), 32'd0);
        chk("npor_tmo",     32'(bus.drain_timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
